// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encodings and character helpers for the UART
// command/LED controller.
package uart_cmd_pkg;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_B  = 8'h42;
  localparam logic [7:0] CH_C  = 8'h43;
  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_QM = 8'h3F;

  typedef enum logic [1:0] {P_IDLE, P_ARG, P_NOARG, P_DISC} parse_state_t;
  typedef enum logic [1:0] {T_IDLE, T_HOLD, T_WAIT} tx_state_t;

  // Returns {valid, nibble}; accepts 0-9, A-F and a-f.
  function automatic logic [4:0] hex_to_nibble(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)
      r = {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      r = {1'b1, 4'(c[3:0] + 4'd9)};
    return r;
  endfunction

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? (c & 8'hDF) : c;
  endfunction

endpackage

// File: rtl/uart_cmd_led_ctrl_byte_fifo.sv
// Byte FIFO with an extra pointer bit to tell full from empty; a pop in the
// same cycle frees the slot a push into a full FIFO needs.
module byte_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_cmd_led_ctrl.sv
// Line-based ASCII LED command parser with byte echo and one-byte status
// replies, all serialised to uart_tx through a byte FIFO.
module uart_cmd_led_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int NUM_LEDS   = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int ECHO_EN    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic                          tx_busy,
  output logic [7:0]                    tx_data,
  output logic                          tx_start,
  output logic [NUM_LEDS-1:0]           led_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  logic [7:0] rx_up;
  logic [4:0] nib;
  logic       is_term, is_sb, is_ca;

  assign rx_up   = to_upper(rx_data);
  assign nib     = hex_to_nibble(rx_up);
  assign is_term = (rx_data == CH_CR) || (rx_data == CH_LF);
  assign is_sb   = (rx_up == CH_S) || (rx_up == CH_B);
  assign is_ca   = (rx_up == CH_C) || (rx_up == CH_A);

  // ---------------- parser ----------------
  parse_state_t p_state, p_next;
  logic arg_start, arg_shift, exec_arg, exec_noarg, reply_ok, reply_bad;
  logic [7:0]            cmd_q;
  logic [NUM_LEDS-1:0]   acc_q;
  logic [NUM_LEDS+3:0]   acc_shift;

  assign acc_shift = {acc_q, nib[3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_state <= P_IDLE;
    else        p_state <= p_next;
  end

  always_comb begin
    p_next = p_state;
    if (rx_valid) begin
      unique case (p_state)
        P_IDLE:  p_next = is_sb ? P_ARG : (is_ca ? P_NOARG : (is_term ? P_IDLE : P_DISC));
        P_ARG:   p_next = nib[4] ? P_ARG : (is_term ? P_IDLE : P_DISC);
        P_NOARG: p_next = is_term ? P_IDLE : P_DISC;
        P_DISC:  p_next = is_term ? P_IDLE : P_DISC;
        default: p_next = P_IDLE;
      endcase
    end
  end

  always_comb begin
    arg_start  = 1'b0;
    arg_shift  = 1'b0;
    exec_arg   = 1'b0;
    exec_noarg = 1'b0;
    reply_ok   = 1'b0;
    reply_bad  = 1'b0;
    if (rx_valid) begin
      unique case (p_state)
        P_IDLE:  arg_start = is_sb;
        P_ARG: begin
          arg_shift = nib[4];
          exec_arg  = !nib[4] && is_term;
          reply_ok  = !nib[4] && is_term;
        end
        P_NOARG: begin
          exec_noarg = is_term;
          reply_ok   = is_term;
        end
        P_DISC:  reply_bad = is_term;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_valid && p_state == P_IDLE) cmd_q <= rx_up;
    if (arg_start)      acc_q <= '0;
    else if (arg_shift) acc_q <= acc_shift[NUM_LEDS-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          led_out <= '0;
    else if (exec_arg)   led_out <= (cmd_q == CH_B) ? (led_out ^ acc_q) : acc_q;
    else if (exec_noarg) led_out <= (cmd_q == CH_A) ? '1 : '0;
  end

  // ---------------- FIFO push arbitration ----------------
  // A deferred echo is oldest, then a pending reply, then the live echo; an
  // echo colliding with either pending byte waits one cycle in echo_byte.
  logic       reply_pend, echo_pend, reply_take, echo_req, echo_defer;
  logic [7:0] reply_byte, echo_byte;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_din, fifo_dout;

  assign echo_req   = rx_valid && (ECHO_EN != 0);
  assign echo_defer = echo_req && (echo_pend || reply_pend);

  always_comb begin
    fifo_push  = 1'b0;
    fifo_din   = 8'h00;
    reply_take = 1'b0;
    if (echo_pend) begin
      fifo_push = 1'b1;
      fifo_din  = echo_byte;
    end else if (reply_pend) begin
      fifo_push  = 1'b1;
      fifo_din   = reply_byte;
      reply_take = 1'b1;
    end else if (echo_req) begin
      fifo_push = 1'b1;
      fifo_din  = rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reply_pend <= 1'b0;
      echo_pend  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (reply_ok || reply_bad) reply_pend <= 1'b1;
      else if (reply_take)       reply_pend <= 1'b0;
      echo_pend <= echo_defer;
      if (fifo_push && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reply_ok || reply_bad) reply_byte <= reply_ok ? CH_K : CH_QM;
    if (echo_defer)            echo_byte  <= rx_data;
  end

  byte_fifo #(.DATA_W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_din),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // ---------------- TX sequencer ----------------
  tx_state_t t_state, t_next;
  logic      hold_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_state  <= T_IDLE;
      hold_cnt <= 1'b0;
    end else begin
      t_state  <= t_next;
      hold_cnt <= (t_state == T_HOLD) ? !hold_cnt : 1'b0;
    end
  end

  always_comb begin
    t_next = t_state;
    unique case (t_state)
      T_IDLE:  if (!fifo_empty && !tx_busy) t_next = T_HOLD;
      T_HOLD:  if (hold_cnt)                t_next = T_WAIT;
      T_WAIT:  if (!tx_busy)                t_next = T_IDLE;
      default: t_next = T_IDLE;
    endcase
  end

  assign fifo_pop = (t_state == T_IDLE) && !fifo_empty && !tx_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= fifo_pop;
      if (fifo_pop) tx_data <= fifo_dout;
    end
  end

endmodule

// File: tb/tb_uart_cmd_led_ctrl.sv
// Directed + randomized bench for uart_cmd_led_ctrl with a line-level
// reference model of echoes, replies and the LED register.
module tb_uart_cmd_led_ctrl;

  localparam int NUM_LEDS   = 10;
  localparam int FIFO_DEPTH = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [7:0]          rx_data = 8'h00;
  logic                rx_valid = 1'b0;
  logic                tx_busy;
  logic [7:0]          tx_data;
  logic                tx_start;
  logic [NUM_LEDS-1:0] led_out;
  logic [4:0]          fifo_level;
  logic                overflow;

  uart_cmd_led_ctrl #(.NUM_LEDS(NUM_LEDS), .FIFO_DEPTH(FIFO_DEPTH), .ECHO_EN(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .led_out    (led_out),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #10 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         last_pulse = -100;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] line_q[$];
  int         model_led = 0;
  bit         force_busy = 1'b0;
  int         busy_cnt = 0;

  // Simple uart_tx stand-in: goes busy a cycle after each start pulse.
  assign tx_busy = force_busy || (busy_cnt != 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start)           busy_cnt <= $urandom_range(3, 12);
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && tx_start) begin
      check("tx_spacing", (cyc - last_pulse >= 4) ? 32'd1 : 32'd0, 32'd1);
      last_pulse = cyc;
      got_q.push_back(tx_data);
    end
  end

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction

  function automatic logic [7:0] up(input logic [7:0] c);
    return (c >= "a" && c <= "z") ? c - 8'd32 : c;
  endfunction

  // Whole-line evaluation: a reply depends only on the complete line text.
  task automatic model_byte(input logic [7:0] b, input bit keep_echo);
    logic [7:0] c0;
    bit ok;
    int val, d;
    if (keep_echo) exp_q.push_back(b);
    if (b == 8'h0D || b == 8'h0A) begin
      if (line_q.size() > 0) begin
        c0 = up(line_q[0]);
        ok = 1'b1;
        val = 0;
        if (c0 == 8'h53 || c0 == 8'h42) begin
          for (int i = 1; i < line_q.size(); i++) begin
            d = hexval(line_q[i]);
            if (d < 0) ok = 1'b0;
            else val = (val * 16 + d) % (1 << NUM_LEDS);
          end
          if (ok) model_led = (c0 == 8'h53) ? val : (model_led ^ val);
        end else if (c0 == 8'h43 || c0 == 8'h41) begin
          ok = (line_q.size() == 1);
          if (ok) model_led = (c0 == 8'h43) ? 0 : (1 << NUM_LEDS) - 1;
        end else begin
          ok = 1'b0;
        end
        exp_q.push_back(ok ? 8'h4B : 8'h3F);
      end
      line_q.delete();
    end else begin
      line_q.push_back(b);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit keep_echo);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    model_byte(b, keep_echo);
    @(negedge clk);
    rx_valid = 1'b0;
    if (b == 8'h0D || b == 8'h0A)
      check("led_after_term", 32'(led_out), model_led);
    repeat ($urandom_range(2, 6)) @(negedge clk);
  endtask

  task automatic send_line(input string body, input logic [7:0] term);
    for (int i = 0; i < body.len(); i++) send_byte(body[i], 1'b1);
    send_byte(term, 1'b1);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((got_q.size() < exp_q.size() || fifo_level != 0 || tx_busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_drain_timeout"}, (t < 5000) ? 32'd1 : 32'd0, 32'd1);
    repeat (20) @(negedge clk);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_led"}, 32'(led_out), model_led);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #(20 * 90000);
    $display("FAIL global_timeout: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    string ops, hx, body;
    ops = "SBCAsbcaX";
    hx  = "0123456789abcdefABCDEF";

    repeat (3) @(negedge clk);
    check("rst_led", 32'(led_out), 32'h0);
    check("rst_tx_start", 32'(tx_start), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_level", 32'(fifo_level), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send_line("S3FF", 8'h0D);
    check("t1_led_const", 32'(led_out), 32'h3FF);
    drain("t1");

    send_line("B001", 8'h0A); drain("t2b");
    check("t2_led_b", 32'(led_out), 32'h3FE);
    send_line("C", 8'h0D);    drain("t2c");
    check("t2_led_c", 32'(led_out), 32'h000);
    send_line("a", 8'h0D);    drain("t2a");
    check("t2_led_a", 32'(led_out), 32'h3FF);

    send_line("X12", 8'h0D);  drain("t3x");
    send_line("S12G", 8'h0D); drain("t3g");
    send_byte(8'h0D, 1'b1);   drain("t3bare");
    check("t3_led_const", 32'(led_out), 32'h3FF);

    send_line("S12345", 8'h0D); drain("t5");
    check("t5_led_const", 32'(led_out), 32'h345);

    for (int k = 0; k < 12; k++) begin
      body = "";
      body = {body, string'(ops[$urandom_range(0, 8)])};
      for (int j = 0; j < $urandom_range(0, 5); j++)
        body = {body, string'(hx[$urandom_range(0, 21)])};
      if ($urandom_range(0, 5) == 0) body = {body, "G"};
      send_line(body, ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A);
      drain($sformatf("rnd%0d", k));
    end

    force_busy = 1'b1;
    for (int i = 0; i < 20; i++)
      send_byte(8'($urandom_range(8'h20, 8'h7E)), (i < FIFO_DEPTH));
    check("ovf_level", 32'(fifo_level), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    force_busy = 1'b0;
    drain("ovf_drain");
    send_byte(8'h0D, 1'b1);
    drain("ovf_term");

    send_byte("S", 1'b1);
    send_byte("1", 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_led", 32'(led_out), 32'h0);
    check("mid_rst_level", 32'(fifo_level), 32'h0);
    check("mid_rst_overflow", 32'(overflow), 32'h0);
    got_q.delete();
    exp_q.delete();
    line_q.delete();
    model_led = 0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_line("5", 8'h0D);
    drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_led_ctrl.md
Name: uart_cmd_led_ctrl

Overview:
Parametrised successor to the fixed echo + LED path. It sits between uart_rx/uart_tx and the LED bank.
- Echoes every received byte through a byte FIFO, so no echo is dropped while TX is busy.
- Parses line-based ASCII commands that set, clear or toggle NUM_LEDS outputs.
- Queues a one-byte status reply per command line.

Parameters:
NUM_LEDS, 10, width of led_out (1..32)
FIFO_DEPTH, 16, TX byte FIFO entries (power of 2, >=4)
ECHO_EN, 1, 1 = echo every received byte; 0 = replies only

Ports:
clk  input  1  system clock (50 MHz)
rst_n  input  1  asynchronous active-low reset
rx_data  input  8  byte from uart_rx
rx_valid  input  1  single-cycle strobe, rx_data valid
tx_busy  input  1  uart_tx busy
tx_data  output  8  byte to uart_tx, stable while tx_start high
tx_start  output  1  single-cycle TX start pulse
led_out  output  NUM_LEDS  LED pattern
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  output  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset (async assert, sync deassert handled upstream): led_out=0, tx_start=0, tx_data=0x00, overflow=0, FIFO empty, parser P_IDLE, TX FSM T_IDLE. Reset mid-command discards the partial line and the queued bytes.
- Terminator: CR (0x0D) or LF (0x0A). Letters and hex digits are case-insensitive.
- Commands:
  - S<hex>: led_out = value.
  - B<hex>: led_out ^= value.
  - C: led_out = 0.
  - A: led_out = all ones.
- Hex accumulation: acc = (acc<<4)|digit, truncated to NUM_LEDS bits. Unlimited digit count. S/B with zero digits gives value 0.
- Parser FSM:
  - P_IDLE: S or B -> P_ARG (acc=0). C or A -> P_NOARG. Terminator -> P_IDLE, no reply. Any other byte -> P_DISC.
  - P_ARG: hex digit -> accumulate. Terminator -> execute, reply 'K' (0x4B), go to P_IDLE. Other byte -> P_DISC.
  - P_NOARG: terminator -> execute, reply 'K'. Other byte -> P_DISC.
  - P_DISC: ignore bytes until terminator, then reply '?' (0x3F), led unchanged, go to P_IDLE.
- led_out updates the clock after the terminator's rx_valid cycle.
- FIFO push order:
  - Echo (if ECHO_EN) is pushed in the rx_valid cycle.
  - The reply is held in a pending register and pushed on the next cycle with no echo push. Terminator echo therefore always precedes its reply.
  - A new line may begin while a reply is pending; the reply still precedes that line's echoes.
- FIFO full on push: byte dropped, overflow<=1 (cleared only by reset). Simultaneous push and pop when full: the pop frees space first, so the push succeeds.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by the extra pointer bit.
- TX FSM:
  - T_IDLE: FIFO non-empty and !tx_busy -> pop, tx_data<=head, tx_start=1 for exactly one cycle -> T_HOLD.
  - T_HOLD: 2 cycles, tx_busy ignored (covers uart_tx busy latency) -> T_WAIT.
  - T_WAIT: tx_busy==0 -> T_IDLE.
  - Minimum pulse spacing is 4 cycles. tx_data is held until the next pop.

Decomposition:
- Package uart_cmd_pkg holds:
  - ASCII constants: CR, LF, 'S', 'B', 'C', 'A', 'K', '?'.
  - Parser state enum (P_IDLE, P_ARG, P_NOARG, P_DISC) and TX state enum (T_IDLE, T_HOLD, T_WAIT).
  - Function hex_to_nibble returning {valid, nibble}.
- One sub-module, byte_fifo: DATA_W=8, DEPTH; push/pop/full/empty/level. Parser, reply pending logic and TX FSM stay in the top block.

Test Plan:
1. Send "S3FF\r" with tx_busy idle -> TX sequence 'S','3','F','F',0x0D,'K'; led_out=0x3FF one cycle after the CR strobe.
2. From 0x3FF send "B001\n" -> 0x3FE; then "C\r" -> 0x000; then "a\r" -> 0x3FF; each line followed by 'K'.
3. Send "X12\r" and "S12G\r" -> each echoed then '?'; led_out unchanged; bare "\r" -> echo only, no reply.
4. Hold tx_busy=1, send 20 bytes (FIFO_DEPTH=16) -> fifo_level=16, overflow=1. Release tx_busy -> exactly 16 tx_start pulses carrying the first 16 bytes in order, each ≥4 cycles apart.
5. Send "S12345\r" with NUM_LEDS=10 -> led_out=0x345 (truncated), reply 'K'.
6. Send "S1", pulse rst_n low mid-line, then "5\r" -> after reset led_out=0, FIFO empty; '5' treated as an invalid command, so echo '5', 0x0D, then '?'.
